// File: rtl/i2s_tx_pkg.sv
// Shared definitions for the I2S transmitter: channel encoding on WS and
// the width of the per-frame bit counter.
package i2s_tx_pkg;

    localparam logic I2S_LEFT      = 1'b0;
    localparam logic I2S_RIGHT     = 1'b1;
    localparam int   I2S_SLOT_MAX  = 32;
    // Counter spans a full frame of two maximum-width slots.
    localparam int   I2S_CNT_W     = $clog2(2 * I2S_SLOT_MAX);

    typedef enum logic {
        CH_LEFT  = I2S_LEFT,
        CH_RIGHT = I2S_RIGHT
    } i2s_ch_e;

endpackage

// File: rtl/i2s_tx_clkgen.sv
// SCK generator: divides clk by 2*div and flags the clk cycle whose closing
// edge takes SCK from 1 to 0. Everything on the serial side moves on that edge.
module i2s_tx_clkgen #(
    parameter int div = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sck_o,
    output logic fall_o
);

    localparam int            DW   = (div > 1) ? $clog2(div) : 1;
    localparam logic [DW-1:0] LAST = DW'(div - 1);

    logic [DW-1:0] hcnt_q, hcnt_d;
    logic          sck_q, sck_d;
    logic          wrap;

    assign wrap = (hcnt_q == LAST);

    // Half-period counter; SCK toggles on each wrap.
    always_comb begin
        hcnt_d = wrap ? '0 : hcnt_q + DW'(1);
        sck_d  = wrap ? ~sck_q : sck_q;
    end

    // Divider state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            sck_q  <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            sck_q  <= sck_d;
        end
    end

    assign sck_o  = sck_q;
    assign fall_o = wrap & sck_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter. A one-deep buffer takes L/R pairs over valid/ready;
// at each frame start the buffer moves into the frame register, which is then
// shifted out MSB first, left slot with WS=0 and right slot with WS=1.
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int b   = 16,
    parameter int s   = 16,
    parameter int div = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [b-1:0] in_l,
    input  logic [b-1:0] in_r,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         underrun,
    output logic         sck,
    output logic         ws,
    output logic         sd
);

    localparam int            CW       = I2S_CNT_W;
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * s - 1);
    localparam logic [CW-1:0] S_C      = CW'(s);

    logic          fall;
    logic [CW-1:0] cnt_q, cnt_d, cnt_nx, pos;
    logic          frame_start, load, slot_r, bit_sel;
    logic [b-1:0]  word;
    logic [b-1:0]  buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [b-1:0]  frm_l_q, frm_l_d, frm_r_q, frm_r_d;
    logic          full_q, full_d;
    i2s_ch_e       ws_q, ws_d;
    logic          sd_q, sd_d;
    logic          underrun_q, underrun_d;

    i2s_tx_clkgen #(.div(div)) u_clkgen (
        .clk    (clk),
        .rst_n  (rst_n),
        .sck_o  (sck),
        .fall_o (fall)
    );

    // Bit counter advances once per SCK, wrapping at the end of the frame.
    always_comb begin
        cnt_d = cnt_q;
        if (fall) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign frame_start = fall && (cnt_d == '0);
    assign load        = frame_start && full_q;

    // Serial mux: on a loading frame start the MSB must come straight from
    // the buffer, since the frame register only updates on this same edge.
    always_comb begin
        slot_r  = (cnt_d >= S_C);
        pos     = slot_r ? cnt_d - S_C : cnt_d;
        word    = slot_r ? (load ? buf_r_q : frm_r_q)
                         : (load ? buf_l_q : frm_l_q);
        bit_sel = 1'b0;
        for (int i = 0; i < b; i++) begin
            if (pos == CW'(b - 1 - i)) bit_sel = word[i];
        end
        // WS runs one bit ahead so it flips during the previous word's LSB.
        cnt_nx = (cnt_d == CNT_LAST) ? '0 : cnt_d + CW'(1);
        ws_d   = ws_q;
        sd_d   = sd_q;
        if (fall) begin
            ws_d = (cnt_nx >= S_C) ? CH_RIGHT : CH_LEFT;
            sd_d = bit_sel;
        end
    end

    // Holding buffer and frame register; ready is low while loading so a
    // new acceptance can never coincide with a load.
    always_comb begin
        full_d  = full_q;
        buf_l_d = buf_l_q;
        buf_r_d = buf_r_q;
        if (load) begin
            full_d = 1'b0;
        end else if (in_valid && !full_q) begin
            full_d  = 1'b1;
            buf_l_d = in_l;
            buf_r_d = in_r;
        end
        frm_l_d    = load ? buf_l_q : frm_l_q;
        frm_r_d    = load ? buf_r_q : frm_r_q;
        underrun_d = frame_start && !full_q;
    end

    // Serial-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= CNT_LAST;
            ws_q       <= CH_LEFT;
            sd_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ws_q       <= ws_d;
            sd_q       <= sd_d;
            underrun_q <= underrun_d;
        end
    end

    // Data-path registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            buf_l_q <= '0;
            buf_r_q <= '0;
            frm_l_q <= '0;
            frm_r_q <= '0;
        end else begin
            full_q  <= full_d;
            buf_l_q <= buf_l_d;
            buf_r_q <= buf_r_d;
            frm_l_q <= frm_l_d;
            frm_r_q <= frm_r_d;
        end
    end

    assign in_ready = !full_q;
    assign underrun = underrun_q;
    assign ws       = ws_q;
    assign sd       = sd_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a 16/16 instance and a 16/24 instance, each
// decoded by a small I2S receiver sampling on SCK rising edges.
module tb_i2s_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [15:0] in_l = '0, in_r = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, underrun, sck, ws, sd;

    logic [15:0] l24 = '0, r24 = '0;
    logic        v24 = 1'b0;
    logic        rdy24, ur24, sck24, ws24, sd24;

    i2s_tx #(.b(16), .s(16), .div(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_l(in_l), .in_r(in_r),
        .in_valid(in_valid), .in_ready(in_ready), .underrun(underrun),
        .sck(sck), .ws(ws), .sd(sd)
    );

    i2s_tx #(.b(16), .s(24), .div(2)) dut24 (
        .clk(clk), .rst_n(rst_n), .in_l(l24), .in_r(r24),
        .in_valid(v24), .in_ready(rdy24), .underrun(ur24),
        .sck(sck24), .ws(ws24), .sd(sd24)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] q_l[$], q_r[$], q24_l[$], q24_r[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Receivers: a word ends on the bit where WS changes.
    logic [31:0] sr16 = '0, w16;
    logic        pws16 = 1'b0, psck16 = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            sr16 = '0; pws16 = 1'b0; psck16 = 1'b0;
        end else begin
            if (sck && !psck16) begin
                w16 = {sr16[30:0], sd};
                if (ws !== pws16) begin
                    if (pws16) q_r.push_back(w16 & 32'h0000FFFF);
                    else       q_l.push_back(w16 & 32'h0000FFFF);
                    sr16 = '0;
                end else sr16 = w16;
                pws16 = ws;
            end
            psck16 = sck;
        end
    end

    logic [31:0] sr24 = '0, w24;
    logic        pws24 = 1'b0, psck24 = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            sr24 = '0; pws24 = 1'b0; psck24 = 1'b0;
        end else begin
            if (sck24 && !psck24) begin
                w24 = {sr24[30:0], sd24};
                if (ws24 !== pws24) begin
                    if (pws24) q24_r.push_back(w24 & 32'h00FFFFFF);
                    else       q24_l.push_back(w24 & 32'h00FFFFFF);
                    sr24 = '0;
                end else sr24 = w24;
                pws24 = ws24;
            end
            psck24 = sck24;
        end
    end

    task automatic pop_chk(input string tag, input int which, input logic [31:0] exp);
        logic [31:0] got;
        got = 32'hxxxxxxxx;
        case (which)
            0: if (q_l.size() > 0)   got = q_l.pop_front();
            1: if (q_r.size() > 0)   got = q_r.pop_front();
            2: if (q24_l.size() > 0) got = q24_l.pop_front();
            default: if (q24_r.size() > 0) got = q24_r.pop_front();
        endcase
        chk(tag, got, exp);
    endtask

    // Negedges until the selected underrun is seen (bounded).
    task automatic wait_ur(input int sel, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((sel == 0) ? underrun : ur24) && n < limit);
    endtask

    task automatic push16(input logic [15:0] l, input logic [15:0] r);
        int n;
        in_l = l; in_r = r; in_valid = 1'b1; n = 0;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("push_timeout", 32'(n < 400), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ur, rises, ws_hi, sd_hi, first_r, second_r, n_push;
        logic p, acc;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_ws", 32'(ws), 32'd0);
        chk("rst_sd", 32'(sd), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_underrun", 32'(underrun), 32'd0);

        // 1: idle link
        rst_n = 1'b1;
        wait_ur(0, 20, n);
        chk("first_underrun_clks", 32'(n), 32'd4);
        @(negedge clk);
        chk("underrun_width", 32'(underrun), 32'd0);
        wait_ur(0, 200, n);
        chk("underrun_period", 32'(n), 32'd127);
        rises = 0; ws_hi = 0; sd_hi = 0; first_r = -1; second_r = -1; p = sck;
        for (int i = 1; i <= 128; i++) begin
            @(negedge clk);
            if (sck && !p) begin
                if (first_r < 0) first_r = i;
                else if (second_r < 0) second_r = i;
                rises++;
                if (ws) ws_hi++;
                if (sd) sd_hi++;
            end
            p = sck;
        end
        chk("sck_period", 32'(second_r - first_r), 32'd4);
        chk("sck_per_frame", 32'(rises), 32'd32);
        chk("ws_high_sck", 32'(ws_hi), 32'd16);
        chk("idle_sd_ones", 32'(sd_hi), 32'd0);
        chk("underrun_frame", 32'(underrun), 32'd1);

        // 2: single pair
        push16(16'hA5C3, 16'h0F0F);
        chk("ready_low", 32'(in_ready), 32'd0);
        n = 1;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("ready_return_clks", 32'(n), 32'd128);
        chk("no_underrun_on_load", 32'(underrun), 32'd0);
        q_l.delete(); q_r.delete();
        repeat (130) @(negedge clk);
        pop_chk("frame_l", 0, 32'h0000A5C3);
        pop_chk("frame_r", 1, 32'h00000F0F);

        // 3: repeat on starvation
        ur = 0;
        repeat (256) begin
            @(negedge clk);
            ur += 32'(underrun);
        end
        chk("repeat_underruns", 32'(ur), 32'd2);
        for (int k = 0; k < 2; k++) begin
            pop_chk("repeat_l", 0, 32'h0000A5C3);
            pop_chk("repeat_r", 1, 32'h00000F0F);
        end

        // 5: streaming source
        wait_ur(0, 200, n);
        chk("stream_sync", 32'(underrun), 32'd1);
        q_l.delete(); q_r.delete();
        in_l = 16'h1000; in_r = 16'h2000; in_valid = 1'b1;
        ur = 0; n_push = 0;
        repeat (700) begin
            acc = in_ready;
            if (acc) n_push++;
            @(negedge clk);
            ur += 32'(underrun);
            if (acc) begin
                in_l++;
                in_r++;
            end
        end
        in_valid = 1'b0;
        chk("stream_pushes", 32'(n_push), 32'd6);
        chk("stream_underruns", 32'(ur), 32'd0);
        repeat (300) @(negedge clk);
        while (q_l.size() > 0 && q_l[0] == 32'h0000A5C3) void'(q_l.pop_front());
        while (q_r.size() > 0 && q_r[0] == 32'h00000F0F) void'(q_r.pop_front());
        for (int k = 0; k < 6; k++) begin
            pop_chk("stream_l", 0, 32'h1000 + 32'(k));
            pop_chk("stream_r", 1, 32'h2000 + 32'(k));
        end

        // 4: 24-bit slots
        wait_ur(1, 400, n);
        wait_ur(1, 400, n);
        chk("s24_underrun_period", 32'(n), 32'd192);
        l24 = 16'h8001; r24 = 16'h7FFE; v24 = 1'b1;
        @(negedge clk);
        v24 = 1'b0;
        chk("s24_ready_low", 32'(rdy24), 32'd0);
        n = 1;
        while (!rdy24 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("s24_ready_return", 32'(n), 32'd192);
        q24_l.delete(); q24_r.delete();
        repeat (200) @(negedge clk);
        pop_chk("s24_l", 2, 32'h00800100);
        pop_chk("s24_r", 3, 32'h007FFE00);

        // 6: reset mid-frame
        push16(16'hFFFF, 16'hFFFF);
        n = 0;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        push16(16'h1234, 16'h5678);
        n = 0;
        while (!(ws && sck && sd) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_active", 32'({ws, sck, sd}), 32'd7);
        chk("pre_reset_full", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_sck", 32'(sck), 32'd0);
        chk("async_ws", 32'(ws), 32'd0);
        chk("async_sd", 32'(sd), 32'd0);
        chk("async_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q_l.delete(); q_r.delete();
        wait_ur(0, 20, n);
        chk("post_reset_underrun", 32'(n), 32'd4);
        repeat (130) @(negedge clk);
        pop_chk("post_reset_l", 0, 32'h0);
        pop_chk("post_reset_r", 1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
